// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, S-box table, NOC16 command codes and key-expander state type
package aes_pkg;

   localparam logic [7:0] CMD_RK   = 8'h00;
   localparam logic [7:0] CMD_IV   = 8'h01;
   localparam logic [7:0] CMD_DATA = 8'h02;
   localparam logic [7:0] CMD_KEY  = 8'h10;

   localparam logic [3:0] ROUND_LAST = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_KEY_HI  = 2'd1,
      ST_EMIT_LO = 2'd2,
      ST_EMIT_HI = 2'd3
   } kx_state_e;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // Round constant for schedule step idx (1..10); zero outside that range so the
   // look-ahead after the last round never indexes past the table.
   function automatic logic [7:0] rcon_of(input logic [3:0] idx);
      if (idx >= 4'd1 && idx <= 4'd10) begin
         return RCON[idx];
      end
      return 8'h00;
   endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - NOC16 beat channel (64-bit chunk, command code, valid/ready)
interface aes_key_expander_if;
   logic [63:0] lo;
   logic [7:0]  cmd;
   logic        valid;
   logic        rdy;

   modport master (output lo, output cmd, output valid, input rdy);
   modport slave  (input lo, input cmd, input valid, output rdy);
endinterface

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - one AES-128 key schedule step, purely combinational
module aes_key_round
   import aes_pkg::*;
(
   input  logic [127:0] rk_in,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, t;
   logic [31:0] n0, n1, n2, n3;

   assign w0 = rk_in[31:0];
   assign w1 = rk_in[63:32];
   assign w2 = rk_in[95:64];
   assign w3 = rk_in[127:96];

   // Byte 0 sits in the LSB, so rotating bytes toward index 0 is a right rotate.
   assign rot = {w3[7:0], w3[31:8]};
   assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {24'h0, rcon};

   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign rk_out = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - takes a 2-beat AES-128 key, streams 11 round keys as 22 TX beats
module aes_key_expander
   import aes_pkg::*;
#(
   parameter logic [7:0] KEY_CMD = CMD_KEY,
   parameter logic [7:0] OUT_CMD = CMD_RK
) (
   input  logic               clk,
   input  logic               reset,
   aes_key_expander_if.slave  rx,
   aes_key_expander_if.master tx,
   output logic               busy
);

   kx_state_e     state_q, state_d;
   logic [63:0]   key_lo_q, key_lo_d;
   logic [127:0]  rk_q, rk_d;
   logic [3:0]    round_q, round_d;
   logic          tx_valid_q, tx_valid_d;
   logic [63:0]   tx_lo_q, tx_lo_d;
   logic [7:0]    tx_cmd_q, tx_cmd_d;
   logic          busy_q, busy_d;

   logic          rx_rdy;
   logic          rx_key_fire;
   logic          tx_fire;
   logic [3:0]    round_inc;
   logic [127:0]  rk_next;

   assign rx_rdy      = !reset && (state_q == ST_IDLE || state_q == ST_KEY_HI);
   assign rx_key_fire = rx.valid && rx_rdy && (rx.cmd == KEY_CMD);
   assign tx_fire     = tx_valid_q && tx.rdy;
   assign round_inc   = round_q + 4'd1;

   // Next round key is ready while the high half of the current one is on the bus.
   aes_key_round u_round (
      .rk_in  (rk_q),
      .rcon   (rcon_of(round_inc)),
      .rk_out (rk_next)
   );

   assign rx.rdy   = rx_rdy;
   assign tx.lo    = tx_lo_q;
   assign tx.cmd   = tx_cmd_q;
   assign tx.valid = tx_valid_q;
   assign busy     = busy_q;

   // State and datapath registers; reset abandons any stream in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         key_lo_q   <= '0;
         rk_q       <= '0;
         round_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_lo_q    <= '0;
         tx_cmd_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_lo_q   <= key_lo_d;
         rk_q       <= rk_d;
         round_q    <= round_d;
         tx_valid_q <= tx_valid_d;
         tx_lo_q    <= tx_lo_d;
         tx_cmd_q   <= tx_cmd_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state: collect key halves, then alternate low/high halves of each round key.
   always_comb begin
      state_d    = state_q;
      key_lo_d   = key_lo_q;
      rk_d       = rk_q;
      round_d    = round_q;
      tx_valid_d = tx_valid_q;
      tx_lo_d    = tx_lo_q;
      tx_cmd_d   = tx_cmd_q;
      busy_d     = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_key_fire) begin
               key_lo_d = rx.lo;
               state_d  = ST_KEY_HI;
            end
         end
         ST_KEY_HI: begin
            if (rx_key_fire) begin
               rk_d       = {rx.lo, key_lo_q};
               round_d    = 4'd0;
               tx_valid_d = 1'b1;
               tx_lo_d    = key_lo_q;
               tx_cmd_d   = OUT_CMD;
               busy_d     = 1'b1;
               state_d    = ST_EMIT_LO;
            end
         end
         ST_EMIT_LO: begin
            if (tx_fire) begin
               tx_lo_d = rk_q[127:64];
               state_d = ST_EMIT_HI;
            end
         end
         ST_EMIT_HI: begin
            if (tx_fire) begin
               if (round_q != ROUND_LAST) begin
                  rk_d    = rk_next;
                  tx_lo_d = rk_next[63:0];
                  round_d = round_inc;
                  state_d = ST_EMIT_LO;
               end else begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander
`timescale 1ns/1ps
module tb_aes_key_expander;

   localparam logic [7:0] KEY  = 8'h10;
   localparam logic [7:0] DATA = 8'h02;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   aes_key_expander_if rx_if ();
   aes_key_expander_if tx_if ();

   aes_key_expander dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx_if),
      .tx    (tx_if),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc = 0;
   logic        stall_mode = 1'b0;
   logic [7:0]  sb [256];
   logic [63:0] exp_beats [22];
   logic [63:0] got_q [$];
   int          got_cyc [$];
   logic        stall_pend = 1'b0;
   logic [63:0] stall_lo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   function automatic void build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic void build_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {24'h0, rc};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) begin
         exp_beats[2*r]   = {w[4*r+1], w[4*r]};
         exp_beats[2*r+1] = {w[4*r+3], w[4*r+2]};
      end
   endfunction

   // TX ready pattern: held high or 50% random, changed just after each rising edge.
   initial begin
      tx_if.rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_if.rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // TX monitor: collects transferred beats and checks hold-stable under backpressure.
   initial begin
      forever begin
         @(negedge clk);
         if (stall_pend && !reset) begin
            chk("stall_valid", 64'(tx_if.valid), 64'd1);
            chk("stall_lo", tx_if.lo, stall_lo);
         end
         if (!reset && tx_if.valid && tx_if.rdy) begin
            got_q.push_back(tx_if.lo);
            got_cyc.push_back(cyc);
            chk("tx_cmd", 64'(tx_if.cmd), 64'h00);
         end
         stall_pend = !reset && tx_if.valid && !tx_if.rdy;
         stall_lo   = tx_if.lo;
      end
   end

   task automatic send_beat(input logic [63:0] lo, input logic [7:0] cmd, input int budget);
      bit ok = 0;
      rx_if.lo    = lo;
      rx_if.cmd   = cmd;
      rx_if.valid = 1'b1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (rx_if.rdy) ok = 1;
         @(posedge clk);
         #1;
      end
      rx_if.valid = 1'b0;
      if (!ok) chk("rx_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && got_q.size() < n; i++) @(posedge clk);
      #1;
      if (got_q.size() < n) chk("tx_beats_timeout", 64'(got_q.size()), 64'(n));
   endtask

   task automatic compare_stream(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'd22);
      for (int i = 0; i < 22 && i < got_q.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_beats[i]);
   endtask

   task automatic clear_stream();
      got_q.delete();
      got_cyc.delete();
   endtask

   // Sends the high key beat (low beat already accepted), then checks the whole stream.
   task automatic finish_key(input logic [127:0] k, input string tag);
      build_model(k);
      send_beat(k[127:64], KEY, 50);
      chk({tag, "_first_valid"}, 64'(tx_if.valid), 64'd1);
      chk({tag, "_first_lo"}, tx_if.lo, exp_beats[0]);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_rx_rdy_busy"}, 64'(rx_if.rdy), 64'd0);
      wait_beats(22, 500);
      compare_stream(tag);
      chk({tag, "_end_valid"}, 64'(tx_if.valid), 64'd0);
      chk({tag, "_end_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic run_key(input logic [127:0] k, input string tag);
      send_beat(k[63:0], KEY, 50);
      finish_key(k, tag);
   endtask

   initial begin
      logic [127:0] fips_key;
      logic [127:0] ka, kb;

      build_sbox();
      fips_key = {64'h3c4fcf098815f7ab, 64'ha6d2ae2816157e2b};
      rx_if.lo    = '0;
      rx_if.cmd   = '0;
      rx_if.valid = 1'b0;
      reset       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_rdy", 64'(rx_if.rdy), 64'd0);
      chk("rst_tx_valid", 64'(tx_if.valid), 64'd0);
      chk("rst_tx_lo", tx_if.lo, 64'd0);
      chk("rst_tx_cmd", 64'(tx_if.cmd), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      #1;
      chk("idle_rx_rdy", 64'(rx_if.rdy), 64'd1);
      @(posedge clk);
      #1;

      // FIPS-197 key, no backpressure: published vectors and back-to-back beats.
      clear_stream();
      run_key(fips_key, "fips");
      chk("fips_b0", got_q[0], 64'ha6d2ae2816157e2b);
      chk("fips_b2", got_q[2], 64'hb12c548817fefaa0);
      chk("fips_b20", got_q[20], 64'h8925eec9a8f914d0);
      chk("fips_b21", got_q[21], 64'ha60c63b6c80c3fe1);
      chk("fips_no_bubble", 64'(got_cyc[21] - got_cyc[0]), 64'd21);
      clear_stream();

      // Same key under random backpressure.
      stall_mode = 1'b1;
      run_key(fips_key, "stall");
      clear_stream();
      stall_mode = 1'b0;
      @(posedge clk);
      #1;

      // Foreign command between key beats is dropped without advancing.
      send_beat(fips_key[63:0], KEY, 50);
      send_beat(64'hdeadbeefcafef00d, DATA, 50);
      chk("drop_valid", 64'(tx_if.valid), 64'd0);
      chk("drop_busy", 64'(busy), 64'd0);
      finish_key(fips_key, "drop");
      clear_stream();

      // Key beat offered while busy waits until the stream has completed.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      build_model(ka);
      send_beat(ka[63:0], KEY, 50);
      send_beat(ka[127:64], KEY, 50);
      rx_if.lo    = kb[63:0];
      rx_if.cmd   = KEY;
      rx_if.valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("busy_block_rdy", 64'(rx_if.rdy), 64'd0);
         @(posedge clk);
         #1;
      end
      send_beat(kb[63:0], KEY, 100);
      chk("busy_a_done", 64'(got_q.size()), 64'd22);
      compare_stream("busy_a");
      clear_stream();
      finish_key(kb, "busy_b");
      clear_stream();

      // Reset in mid-stream, then a full key is required again.
      send_beat(ka[63:0], KEY, 50);
      send_beat(ka[127:64], KEY, 50);
      for (int i = 0; i < 200 && got_q.size() < 7; i++) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_valid", 64'(tx_if.valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_stream();
      send_beat(kb[63:0], KEY, 50);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_half_key_idle", 64'(tx_if.valid), 64'd0);
      finish_key(kb, "midrst");
      clear_stream();

      // All-zero key.
      run_key(128'h0, "zero");
      chk("zero_b2", got_q[2], 64'h6363636263636362);
      chk("zero_b3", got_q[3], 64'h6363636263636362);
      clear_stream();

      // Random keys under random backpressure.
      stall_mode = 1'b1;
      for (int n = 0; n < 4; n++) begin
         ka = {$urandom, $urandom, $urandom, $urandom};
         run_key(ka, $sformatf("rand%0d", n));
         clear_stream();
      end
      stall_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
